// File: rtl/pc_sequencer.sv
// pc_sequencer: drives the fetch-stage PC counter en/load/data_in pins.
// Optional macro PCSEQ_EXC_EN enables exceptions, misaligned-target traps and epc.
//
// Ports:
//   i_clk, i_clr            clock, synchronous active-high reset
//   i_pc_cur                current counter value
//   i_stall                 hold PC this cycle
//   i_br_req/i_br_target    taken branch and its target
//   i_jmp_req/i_jmp_target  jump and its target
//   i_halt_req, i_resume    enter / leave HALT
//   i_exc_req               exception request (only with PCSEQ_EXC_EN)
//   o_pc_en, o_pc_load      counter enable / load
//   o_pc_data               counter load value
//   o_fetch_valid, o_flush  fetch qualifiers
//   o_halted                high in HALT
//   o_epc                   exception return PC
module pc_sequencer #(
   parameter int                   DATAWIDTH    = 32,
   parameter logic [DATAWIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [DATAWIDTH-1:0] EXC_VECTOR   = DATAWIDTH'(32'h0000_0180)
) (
   input  logic                 i_clk,
   input  logic                 i_clr,
   input  logic [DATAWIDTH-1:0] i_pc_cur,
   input  logic                 i_stall,
   input  logic                 i_br_req,
   input  logic [DATAWIDTH-1:0] i_br_target,
   input  logic                 i_jmp_req,
   input  logic [DATAWIDTH-1:0] i_jmp_target,
   input  logic                 i_halt_req,
   input  logic                 i_resume,
   input  logic                 i_exc_req,
   output logic                 o_pc_en,
   output logic                 o_pc_load,
   output logic [DATAWIDTH-1:0] o_pc_data,
   output logic                 o_fetch_valid,
   output logic                 o_flush,
   output logic                 o_halted,
   output logic [DATAWIDTH-1:0] o_epc
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [DATAWIDTH-1:0] w_br_al;
   logic [DATAWIDTH-1:0] w_jmp_al;
   logic                 w_exc_run;
   logic                 w_exc_halt;
   logic                 w_redir;
   logic                 w_epc_ld;

   assign w_br_al  = {i_br_target[DATAWIDTH-1:2], 2'b00};
   assign w_jmp_al = {i_jmp_target[DATAWIDTH-1:2], 2'b00};

`ifdef PCSEQ_EXC_EN
   // A misaligned redirect target traps with exception priority.
   assign w_exc_run  = i_exc_req
                     | (i_br_req & (|i_br_target[1:0]))
                     | (i_jmp_req & (|i_jmp_target[1:0]));
   assign w_exc_halt = i_exc_req;
`else
   assign w_exc_run  = 1'b0;
   assign w_exc_halt = 1'b0;
`endif

   assign w_redir = w_exc_run | i_jmp_req | i_br_req;

   always_ff @(posedge i_clk) begin
      if (i_clr) r_state <= S_BOOT;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_BOOT:  w_next = S_RUN;
         S_RUN:   if (i_halt_req) w_next = S_HALT;
         S_HALT:  if (w_exc_halt | i_resume) w_next = S_RUN;
         default: w_next = S_BOOT;
      endcase
   end

   always_comb begin
      o_pc_en       = 1'b0;
      o_pc_load     = 1'b0;
      o_pc_data     = RESET_VECTOR;
      o_fetch_valid = 1'b0;
      o_flush       = 1'b0;
      o_halted      = 1'b0;
      w_epc_ld      = 1'b0;
      if (!i_clr) begin
         case (r_state)
            S_BOOT: begin
               o_pc_en   = 1'b1;
               o_pc_load = 1'b1;
            end
            S_RUN: begin
               o_fetch_valid = 1'b1;
               if (w_redir) begin
                  // Redirect wins over stall and halt.
                  o_pc_en   = 1'b1;
                  o_pc_load = 1'b1;
                  o_flush   = 1'b1;
                  w_epc_ld  = w_exc_run;
                  if (w_exc_run)      o_pc_data = EXC_VECTOR;
                  else if (i_jmp_req) o_pc_data = w_jmp_al;
                  else                o_pc_data = w_br_al;
               end else if (!i_halt_req && !i_stall) begin
                  o_pc_en = 1'b1;
               end
            end
            S_HALT: begin
               o_halted = 1'b1;
               if (w_exc_halt) begin
                  o_pc_en   = 1'b1;
                  o_pc_load = 1'b1;
                  o_pc_data = EXC_VECTOR;
                  w_epc_ld  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef PCSEQ_EXC_EN
   logic [DATAWIDTH-1:0] r_epc;

   always_ff @(posedge i_clk) begin
      if (i_clr)         r_epc <= '0;
      else if (w_epc_ld) r_epc <= i_pc_cur;
   end

   assign o_epc = r_epc;
`else
   logic w_unused;

   assign o_epc    = '0;
   assign w_unused = ^{i_exc_req, i_pc_cur, i_br_target[1:0],
                       i_jmp_target[1:0], w_epc_ld, EXC_VECTOR};
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control block that drives the program counter's `en`/`load`/`data_in` pins in the semiMIPS fetch stage. It decides each cycle whether the PC increments by 4, holds, or loads a redirect target (boot vector, jump, taken branch, exception vector), and tells fetch whether the current PC is valid or must be flushed. It sits between the hazard/branch logic and the PC counter and is the only driver of the counter's control pins.

## Interface
- `DATAWIDTH`, 32, width of PC and targets
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset
- `EXC_VECTOR`, 32'h0000_0180, exception handler address (used only with `PCSEQ_EXC_EN`)

- `clk`  in  1  clock, all state on rising edge
- `clr`  in  1  reset, synchronous, active-high
- `pc_cur`  in  DATAWIDTH  current counter output (`data_out`)
- `stall`  in  1  hazard unit: hold PC this cycle
- `br_req`  in  1  taken branch resolved this cycle
- `br_target`  in  DATAWIDTH  branch target
- `jmp_req`  in  1  jump resolved this cycle
- `jmp_target`  in  DATAWIDTH  jump target
- `halt_req`  in  1  halt instruction retired
- `resume`  in  1  leave HALT
- `exc_req`  in  1  exception request (ignored without macro)
- `pc_en`  out  1  to counter `en`
- `pc_load`  out  1  to counter `load`
- `pc_data`  out  DATAWIDTH  to counter `data_in`
- `fetch_valid`  out  1  `pc_cur` holds a fetchable address this cycle
- `flush`  out  1  kill the instruction fetched this cycle
- `halted`  out  1  high in HALT
- `epc`  out  DATAWIDTH  exception return PC (0 without macro)

## Operation
- States: BOOT, RUN, HALT (2-bit register). `clr` high at an edge -> BOOT; `clr` overrides everything, including mid-redirect or HALT.
- Outputs are combinational from state and inputs; counter acts on the same edge.
- While `clr` high: `pc_en`=0, `pc_load`=0, `pc_data`=RESET_VECTOR, `fetch_valid`=0, `flush`=0, `halted`=0; `epc` register cleared to 0.
- BOOT: `pc_en`=1, `pc_load`=1, `pc_data`=RESET_VECTOR, `fetch_valid`=0; next state RUN unconditionally.
- RUN priority (highest first): `exc_req` -> `jmp_req` -> `br_req` -> `stall` -> increment.
  - Redirect (exc/jmp/br): `pc_en`=1, `pc_load`=1, `pc_data`=selected target, `flush`=1, `fetch_valid`=1. Redirect beats `stall`.
  - `stall` only: `pc_en`=0, `fetch_valid`=1, `flush`=0.
  - Otherwise: `pc_en`=1, `pc_load`=0 (counter adds 4, wraps at its limit).
  - `pc_data`=RESET_VECTOR when `pc_load`=0.
- `halt_req` in RUN: if no redirect, `pc_en`=0. With a simultaneous redirect, the redirect is still loaded. Next state HALT in both cases.
- HALT: `pc_en`=0, `fetch_valid`=0, `halted`=1. `resume` -> RUN next edge, with no PC change on the resume cycle. `exc_req` (macro) loads EXC_VECTOR and -> RUN. `br_req`/`jmp_req` are ignored.
- Target alignment: targets have bits [1:0] forced to 2'b00 before driving `pc_data`.

## Timing
- Redirect latency 1: request in cycle N -> `pc_cur`=target in cycle N+1.
- Boot: `clr` released at edge E -> BOOT in cycle after E -> `pc_cur`=RESET_VECTOR one edge later, `fetch_valid`=1 from then.
- `flush` is high only in the redirect cycle; it is never high in BOOT or HALT.
- `halted` rises the cycle after `halt_req` and falls the cycle after `resume`.

## Configuration
- `PCSEQ_EXC_EN` defined: `exc_req` is honoured in RUN and HALT. When taken, `epc` <= `pc_cur` (registered) and `pc_data`=EXC_VECTOR. A misaligned `br_target`/`jmp_target` (bits [1:0] != 0) is treated as `exc_req` and has the same priority as `exc_req`.
- Not defined: `exc_req` is ignored, `epc` is tied to 0, and misaligned targets are silently forced aligned.

## Test plan
- Reset release, no requests -> BOOT cycle with `pc_load`=1 and `pc_data`=0, then `pc_cur` 0,4,8,12 on successive cycles with `fetch_valid`=1.
- `pc_cur`=0x20, `stall` for 3 cycles -> `pc_en`=0 and `pc_cur` stays 0x20; on release, the next value is 0x24.
- `br_req`=1, `br_target`=0x100, with `stall`=1 and `jmp_req`=1, `jmp_target`=0x200 in the same cycle -> `pc_data`=0x200, `flush`=1, `pc_cur`=0x200 next cycle.
- `halt_req` at `pc_cur`=0x40 -> `halted`=1 next cycle and `pc_cur` frozen at 0x40; `resume` -> `pc_cur` 0x40 then 0x44.
- With `PCSEQ_EXC_EN`: `jmp_target`=0x102 at `pc_cur`=0x50 -> `pc_data`=0x180, `epc`=0x50. Without the macro, the same stimulus -> `pc_data`=0x100.
- `clr` asserted during a HALT and during a redirect cycle -> all outputs at their reset values, and BOOT re-executes after release.
